// File: rtl/palette_pkg.sv
// palette_pkg
// Shared types and constants for the palette fade engine.
//   pal_color_t  : one 12-bit palette colour, 4 bits each of red, green, blue
//   PAL_ENTRIES  : number of palette entries
//   PAL_IDX_W    : width of a palette index
//   fade_state_t : states of the fade sequencer
package palette_pkg;

    localparam int PAL_ENTRIES = 64;
    localparam int PAL_IDX_W   = 6;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pal_color_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        SWEEP
    } fade_state_t;

endpackage

// File: rtl/palette_fader_color_step.sv
// color_step
// Moves each 4-bit component of a colour one step toward a target colour.
//   old_i     : current colour read from the palette
//   tgt_i     : colour being faded toward
//   new_o     : colour after one step
//   changed_o : high when new_o differs from old_i
module color_step
    import palette_pkg::*;
(
    input  pal_color_t old_i,
    input  pal_color_t tgt_i,
    output pal_color_t new_o,
    output logic       changed_o
);

    // A component already at its target stays put; otherwise it moves by one.
    function automatic logic [3:0] stepOne(input logic [3:0] oldVal, input logic [3:0] tgtVal);
        if (oldVal < tgtVal) begin
            return oldVal + 4'd1;
        end else if (oldVal > tgtVal) begin
            return oldVal - 4'd1;
        end else begin
            return oldVal;
        end
    endfunction

    // Step the three components independently so mixed-direction fades work.
    always_comb begin
        new_o.r   = stepOne(old_i.r, tgt_i.r);
        new_o.g   = stepOne(old_i.g, tgt_i.g);
        new_o.b   = stepOne(old_i.b, tgt_i.b);
        changed_o = (new_o != old_i);
    end

endmodule

// File: rtl/palette_fader.sv
// palette_fader
// Shares the palette RAM's single port between the CPU bus and a fade engine.
// On every (fade_rate+1)-th frame tick the engine sweeps all entries and steps
// each colour component one unit toward the latched target.
//   clk, reset_n          : clock and asynchronous active-low reset
//   bus_sel/addr/wrdata/wren, bus_rddata : CPU access, always has priority
//   fade_start/abort/target/rate/tick    : fade control
//   fade_busy, fade_done  : engine status
//   pal_addr/wrdata/wren, pal_rddata     : palette port (combinational read)
module palette_fader
    import palette_pkg::*;
#(
    parameter int NUM_ENTRIES = PAL_ENTRIES,
    parameter int RATE_W      = 4,
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bus_sel,
    input  logic [IDX_W-1:0]  bus_addr,
    input  logic [15:0]       bus_wrdata,
    input  logic              bus_wren,
    output logic [15:0]       bus_rddata,
    input  logic              fade_start,
    input  logic              fade_abort,
    input  logic [11:0]       fade_target,
    input  logic [RATE_W-1:0] fade_rate,
    input  logic              fade_tick,
    output logic              fade_busy,
    output logic              fade_done,
    output logic [IDX_W-1:0]  pal_addr,
    output logic [15:0]       pal_wrdata,
    output logic              pal_wren,
    input  logic [15:0]       pal_rddata
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    fade_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RATE_W-1:0] tickCnt_q, tickCnt_d;
    logic              changed_q, changed_d;
    pal_color_t        tgt_q, tgt_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic              done_q, done_d;

    pal_color_t        oldColor;
    pal_color_t        stepColor;
    logic              stepChanged;
    logic              engineOwns;
    logic              unusedBits;

    assign oldColor   = pal_color_t'(pal_rddata[11:0]);
    assign engineOwns = (state_q == SWEEP) && !bus_sel;
    assign unusedBits = ^{bus_wrdata[15:12], pal_rddata[15:12]};

    color_step u_step (
        .old_i     (oldColor),
        .tgt_i     (tgt_q),
        .new_o     (stepColor),
        .changed_o (stepChanged)
    );

    // Port mux: the CPU always wins; the engine only gets the port in SWEEP
    // cycles the CPU leaves free, and only writes entries that actually move.
    always_comb begin
        bus_rddata = pal_rddata;
        pal_addr   = bus_addr;
        pal_wrdata = {4'h0, bus_wrdata[11:0]};
        pal_wren   = 1'b0;
        if (bus_sel) begin
            pal_wren = bus_wren;
        end else if (state_q == SWEEP) begin
            pal_addr   = idx_q;
            pal_wrdata = {4'h0, stepColor};
            pal_wren   = stepChanged;
        end
    end

    // Sequencer next state. Abort beats start, and start restarts from any
    // state, abandoning any partially completed sweep.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tickCnt_d = tickCnt_q;
        changed_d = changed_q;
        tgt_d     = tgt_q;
        rate_d    = rate_q;
        done_d    = 1'b0;
        if (fade_abort) begin
            state_d = IDLE;
        end else if (fade_start) begin
            tgt_d     = pal_color_t'(fade_target);
            rate_d    = fade_rate;
            tickCnt_d = '0;
            state_d   = WAIT_TICK;
        end else begin
            case (state_q)
                WAIT_TICK: begin
                    if (fade_tick) begin
                        if (tickCnt_q == rate_q) begin
                            tickCnt_d = '0;
                            idx_d     = '0;
                            changed_d = 1'b0;
                            state_d   = SWEEP;
                        end else begin
                            tickCnt_d = tickCnt_q + RATE_W'(1);
                        end
                    end
                end
                SWEEP: begin
                    if (engineOwns) begin
                        changed_d = changed_q | stepChanged;
                        idx_d     = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            if (changed_d) begin
                                state_d = WAIT_TICK;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tickCnt_q <= '0;
            changed_q <= 1'b0;
            tgt_q     <= '0;
            rate_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tickCnt_q <= tickCnt_d;
            changed_q <= changed_d;
            tgt_q     <= tgt_d;
            rate_q    <= rate_d;
            done_q    <= done_d;
        end
    end

    assign fade_busy = (state_q != IDLE);
    assign fade_done = done_q;

endmodule

// File: tb/tb_palette_fader.sv
// tb_palette_fader
// Directed bench for palette_fader with a behavioural 64x16 palette RAM.
module tb_palette_fader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bus_sel;
    logic [5:0]  bus_addr;
    logic [15:0] bus_wrdata;
    logic        bus_wren;
    logic [15:0] bus_rddata;
    logic        fade_start;
    logic        fade_abort;
    logic [11:0] fade_target;
    logic [3:0]  fade_rate;
    logic        fade_tick;
    logic        fade_busy;
    logic        fade_done;
    logic [5:0]  pal_addr;
    logic [15:0] pal_wrdata;
    logic        pal_wren;
    logic [15:0] pal_rddata;

    logic [15:0] mem [64];

    int compared   = 0;
    int mismatched = 0;

    int cyc        = 0;
    int engWrites  = 0;
    int lastEngCyc = 0;
    int tickCyc    = 0;
    int doneCount  = 0;
    int doneBusy   = 0;

    always #5 clk = ~clk;

    palette_fader #(.NUM_ENTRIES(64), .RATE_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_sel     (bus_sel),
        .bus_addr    (bus_addr),
        .bus_wrdata  (bus_wrdata),
        .bus_wren    (bus_wren),
        .bus_rddata  (bus_rddata),
        .fade_start  (fade_start),
        .fade_abort  (fade_abort),
        .fade_target (fade_target),
        .fade_rate   (fade_rate),
        .fade_tick   (fade_tick),
        .fade_busy   (fade_busy),
        .fade_done   (fade_done),
        .pal_addr    (pal_addr),
        .pal_wrdata  (pal_wrdata),
        .pal_wren    (pal_wren),
        .pal_rddata  (pal_rddata)
    );

    // Palette RAM: combinational read, synchronous write.
    assign pal_rddata = mem[pal_addr];
    always @(posedge clk) begin
        if (pal_wren) begin
            mem[pal_addr] <= pal_wrdata;
        end
    end

    // Engine write activity and sweep timing, seen at the active edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pal_wren && !bus_sel) begin
            engWrites  <= engWrites + 1;
            lastEngCyc <= cyc;
        end
        if (fade_tick) begin
            tickCyc <= cyc;
        end
    end

    // Done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (fade_done) begin
            doneCount <= doneCount + 1;
            if (fade_busy) begin
                doneBusy <= doneBusy + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic abort,
                                 input logic [11:0] tgt, input logic [3:0] rate);
        @(negedge clk);
        fade_start  = start;
        fade_abort  = abort;
        fade_target = tgt;
        fade_rate   = rate;
        @(negedge clk);
        fade_start = 1'b0;
        fade_abort = 1'b0;
    endtask

    task automatic pulseTick();
        @(negedge clk);
        fade_tick = 1'b1;
        @(negedge clk);
        fade_tick = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busWrite(input logic [5:0] addr, input logic [11:0] data);
        @(negedge clk);
        bus_sel    = 1'b1;
        bus_wren   = 1'b1;
        bus_addr   = addr;
        bus_wrdata = {4'h0, data};
        @(negedge clk);
        bus_sel  = 1'b0;
        bus_wren = 1'b0;
    endtask

    task automatic loadAll(input logic [11:0] data);
        for (int i = 0; i < 64; i++) begin
            busWrite(6'(i), data);
        end
    endtask

    initial begin
        int d0;
        int w0;
        int allOk;
        logic [11:0] expRate [6];
        logic [11:0] expMix [3];
        logic [3:0] r;
        logic [3:0] er;

        reset_n     = 1'b0;
        bus_sel     = 1'b0;
        bus_addr    = 6'd7;
        bus_wrdata  = 16'h0;
        bus_wren    = 1'b0;
        fade_start  = 1'b0;
        fade_abort  = 1'b0;
        fade_target = 12'h0;
        fade_rate   = 4'h0;
        fade_tick   = 1'b0;

        #1;
        checkOutput("rstBusy", 32'(fade_busy), 32'd0);
        checkOutput("rstDone", 32'(fade_done), 32'd0);
        checkOutput("rstWren", 32'(pal_wren), 32'd0);
        checkOutput("rstAddr", 32'(pal_addr), 32'd7);
        waitCycles(3);
        reset_n = 1'b1;

        // CPU write path through the mux; upper data bits are dropped.
        @(negedge clk);
        bus_sel    = 1'b1;
        bus_wren   = 1'b1;
        bus_addr   = 6'd9;
        bus_wrdata = 16'hF123;
        #1;
        checkOutput("muxWrdata", 32'(pal_wrdata), 32'h0123);
        checkOutput("muxWren", 32'(pal_wren), 32'd1);
        checkOutput("muxAddr", 32'(pal_addr), 32'd9);
        @(negedge clk);
        bus_sel  = 1'b0;
        bus_wren = 1'b0;
        #1;
        checkOutput("busRead", 32'(bus_rddata), 32'h0123);

        // Fade from black to white, one step per tick.
        $display("[TB] fade from black");
        loadAll(12'h000);
        d0 = doneCount;
        applyStimulus(1'b1, 1'b0, 12'hFFF, 4'd0);
        #1;
        checkOutput("blackBusyStart", 32'(fade_busy), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            pulseTick();
            waitCycles(70);
            checkOutput($sformatf("black%0d_e0", k), 32'(mem[0]), (k > 15) ? 32'hFFF : 32'(k * 12'h111));
            checkOutput($sformatf("black%0d_e63", k), 32'(mem[63]), (k > 15) ? 32'hFFF : 32'(k * 12'h111));
            if (k == 1) begin
                checkOutput("sweepLen", 32'(lastEngCyc - tickCyc), 32'd64);
            end
            if (k == 15) begin
                checkOutput("blackNoDoneYet", 32'(doneCount - d0), 32'd0);
                checkOutput("blackBusy15", 32'(fade_busy), 32'd1);
            end
        end
        checkOutput("blackDone", 32'(doneCount - d0), 32'd1);
        checkOutput("doneBusyLow", 32'(doneBusy), 32'd0);
        checkOutput("blackBusyEnd", 32'(fade_busy), 32'd0);
        allOk = 1;
        for (int i = 0; i < 64; i++) begin
            if (mem[i] !== 16'h0FFF) allOk = 0;
        end
        checkOutput("blackAllWhite", 32'(allOk), 32'd1);

        // Rate divider: a step only on every third tick.
        $display("[TB] rate divider");
        loadAll(12'h000);
        busWrite(6'd0, 12'h800);
        applyStimulus(1'b1, 1'b0, 12'h000, 4'd2);
        expRate[0] = 12'h800; expRate[1] = 12'h800; expRate[2] = 12'h700;
        expRate[3] = 12'h700; expRate[4] = 12'h700; expRate[5] = 12'h600;
        for (int k = 0; k < 6; k++) begin
            pulseTick();
            waitCycles(70);
            checkOutput($sformatf("rateTick%0d", k + 1), 32'(mem[0]), 32'(expRate[k]));
            checkOutput($sformatf("rateBusy%0d", k + 1), 32'(fade_busy), 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 12'h000, 4'd0);
        #1;
        checkOutput("rateAbortIdle", 32'(fade_busy), 32'd0);

        // CPU contention: CPU takes the port on every other cycle of the sweep.
        $display("[TB] cpu contention");
        for (int i = 0; i < 64; i++) begin
            busWrite(6'(i), {4'(i >> 2), 4'h0, 4'hF});
        end
        applyStimulus(1'b1, 1'b0, 12'h888, 4'd0);
        w0 = engWrites;
        @(negedge clk);
        fade_tick = 1'b1;
        for (int c = 0; c < 128; c++) begin
            @(negedge clk);
            fade_tick  = 1'b0;
            bus_sel    = (c % 2 == 0);
            bus_wren   = (c == 126);
            bus_addr   = (c == 126) ? 6'd40 : c[5:0];
            bus_wrdata = 16'h00A5;
        end
        @(negedge clk);
        bus_sel  = 1'b0;
        bus_wren = 1'b0;
        waitCycles(5);
        checkOutput("contSweepLen", 32'(lastEngCyc - tickCyc), 32'd128);
        checkOutput("contEngWrites", 32'(engWrites - w0), 32'd64);
        checkOutput("contCpuWrite", 32'(mem[40]), 32'h00A5);
        checkOutput("contE0", 32'(mem[0]), 32'h011E);
        checkOutput("contE20", 32'(mem[20]), 32'h061E);
        checkOutput("contE32", 32'(mem[32]), 32'h081E);
        checkOutput("contE63", 32'(mem[63]), 32'h0E1E);
        allOk = 1;
        for (int i = 0; i < 64; i++) begin
            r  = 4'(i >> 2);
            er = (r < 4'd8) ? r + 4'd1 : (r > 4'd8) ? r - 4'd1 : r;
            if (i != 40 && mem[i] !== {4'h0, er, 4'h1, 4'hE}) allOk = 0;
        end
        checkOutput("contAllStep", 32'(allOk), 32'd1);
        applyStimulus(1'b0, 1'b1, 12'h000, 4'd0);

        // Mixed directions: red rises while green falls and blue holds.
        $display("[TB] mixed directions");
        loadAll(12'h7A7);
        busWrite(6'd5, 12'h4C7);
        d0 = doneCount;
        applyStimulus(1'b1, 1'b0, 12'h7A7, 4'd0);
        expMix[0] = 12'h5B7; expMix[1] = 12'h6A7; expMix[2] = 12'h7A7;
        for (int k = 0; k < 3; k++) begin
            pulseTick();
            waitCycles(70);
            checkOutput($sformatf("mix%0d", k + 1), 32'(mem[5]), 32'(expMix[k]));
            checkOutput($sformatf("mixNoDone%0d", k + 1), 32'(doneCount - d0), 32'd0);
        end
        pulseTick();
        waitCycles(70);
        checkOutput("mixDone", 32'(doneCount - d0), 32'd1);
        checkOutput("mixBusyEnd", 32'(fade_busy), 32'd0);
        checkOutput("mixNeighbour", 32'(mem[4]), 32'h07A7);

        // Restart mid-sweep, then abort+start together.
        $display("[TB] restart and abort");
        loadAll(12'h000);
        applyStimulus(1'b1, 1'b0, 12'hFFF, 4'd0);
        pulseTick();
        waitCycles(30);
        applyStimulus(1'b1, 1'b0, 12'h00F, 4'd0);
        #1;
        checkOutput("restartBusy", 32'(fade_busy), 32'd1);
        @(negedge clk);
        fade_tick = 1'b1;
        @(negedge clk);
        fade_tick = 1'b0;
        #1;
        checkOutput("restartIdx0", 32'(pal_addr), 32'd0);
        checkOutput("restartWrdata", 32'(pal_wrdata), 32'h0002);
        checkOutput("restartWren", 32'(pal_wren), 32'd1);
        waitCycles(10);
        d0 = doneCount;
        applyStimulus(1'b1, 1'b1, 12'hFFF, 4'd0);
        #1;
        w0 = engWrites;
        checkOutput("abortIdle", 32'(fade_busy), 32'd0);
        pulseTick();
        waitCycles(80);
        checkOutput("abortNoWrites", 32'(engWrites - w0), 32'd0);
        checkOutput("abortNoDone", 32'(doneCount - d0), 32'd0);
        checkOutput("abortPartialE0", 32'(mem[0]), 32'h0002);
        checkOutput("abortUntouchedE50", 32'(mem[50]), 32'h0000);

        // Reset in the middle of a sweep.
        $display("[TB] reset mid-sweep");
        loadAll(12'h000);
        applyStimulus(1'b1, 1'b0, 12'hFFF, 4'd0);
        pulseTick();
        waitCycles(10);
        #1;
        checkOutput("preResetWren", 32'(pal_wren), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("resetWren", 32'(pal_wren), 32'd0);
        checkOutput("resetBusy", 32'(fade_busy), 32'd0);
        checkOutput("resetDone", 32'(fade_done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        w0 = engWrites;
        pulseTick();
        waitCycles(70);
        checkOutput("postResetNoWrites", 32'(engWrites - w0), 32'd0);
        checkOutput("postResetBusy", 32'(fade_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/palette_fader.md
# palette_fader

Sequencer and port arbiter for the 64-entry 12-bit palette RAM. It shares the palette's single read/write port between the CPU bus and an internal fade engine. On each qualifying frame tick, the engine sweeps all entries and moves every 4-bit R/G/B component one step toward a target colour. It sits between the CPU register decode and the palette instance, and drives the palette's addr/wrdata/wren/rddata port.

## Interface
Parameters:
- NUM_ENTRIES, 64, palette depth; must be a power of two, and the index width is log2 of it.
- RATE_W, 4, width of the ticks-per-step divider.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- bus_sel  in  1  CPU owns the palette port this cycle (read or write)
- bus_addr  in  6  CPU palette index
- bus_wrdata  in  16  CPU write data; bits [11:0] are used
- bus_wren  in  1  CPU write strobe; ignored unless bus_sel
- bus_rddata  out  16  palette read data, passed through unchanged
- fade_start  in  1  one-cycle pulse that latches fade_target/fade_rate and starts a fade
- fade_abort  in  1  one-cycle pulse that stops the fade immediately
- fade_target  in  12  target colour {R,G,B}
- fade_rate  in  RATE_W  a step happens on every (fade_rate+1)-th tick
- fade_tick  in  1  one-cycle frame pulse (vsync)
- fade_busy  out  1  engine is in WAIT_TICK or SWEEP
- fade_done  out  1  one-cycle pulse when the fade converges
- pal_addr  out  6  to the palette
- pal_wrdata  out  16  to the palette; bits [15:12] are always 0
- pal_wren  out  1  to the palette
- pal_rddata  in  16  from the palette (combinational read)

## Operation
- Port mux (combinational):
  - When bus_sel=1: pal_addr=bus_addr, pal_wrdata={4'h0,bus_wrdata[11:0]}, pal_wren=bus_wren.
  - Otherwise, in SWEEP, the engine drives the port.
  - Otherwise: pal_addr=bus_addr, pal_wren=0.
  - bus_rddata=pal_rddata at all times.
- States: IDLE, WAIT_TICK, SWEEP.
- IDLE:
  - fade_start latches tgt, rate, clears tick_cnt, and goes to WAIT_TICK.
- WAIT_TICK:
  - On fade_tick: if tick_cnt==rate, clear tick_cnt, clear idx and changed, and go to SWEEP. Otherwise tick_cnt+1.
- SWEEP, in each cycle with bus_sel=0:
  - pal_addr=idx; old=pal_rddata[11:0].
  - Per component c: new_c = old_c+1 if old_c<tgt_c, old_c-1 if old_c>tgt_c, else old_c.
  - pal_wren=1 only if new≠old; in that case set changed.
  - Then idx+1.
- SWEEP with bus_sel=1: the engine stalls; idx, changed and the state are held.
- End of sweep, when idx==NUM_ENTRIES-1 is processed:
  - If changed (including a change on this last entry): go to WAIT_TICK.
  - Else: go to IDLE and pulse fade_done.
- fade_tick during SWEEP is ignored and does not count.
- fade_start while busy restarts the fade: re-latch tgt and rate, tick_cnt=0, go to WAIT_TICK. Any partial sweep is abandoned.
- fade_abort in any state goes to IDLE with no fade_done. Entries keep their partially faded values.
- fade_start and fade_abort in the same cycle: abort wins.
- CPU writes during a fade are legal. The engine fades the new value on the next pass that reaches that entry.
- Convergence: from 0xFFF to 0x000 takes 15 changing sweeps plus 1 non-changing sweep, so 16 step events.

## Timing
- Reset values: state=IDLE, idx=0, tick_cnt=0, changed=0, tgt=0, rate=0, fade_busy=0, fade_done=0. pal_wren follows the mux and is 0 when bus_wren=0.
- The palette read is combinational, so each entry is a single-cycle read-modify-write. An uncontended sweep takes exactly NUM_ENTRIES cycles.
- SWEEP starts the cycle after the qualifying fade_tick.
- fade_busy is high from the cycle after fade_start until the cycle after the last sweep ends.
- fade_done is registered and high for exactly 1 cycle, in the cycle after the final sweep entry; fade_busy is 0 in that same cycle.
- fade_abort takes effect the next cycle: no engine write is issued after the abort cycle.
- The CPU never stalls and sees zero added latency.

## Structure
- Shared package palette_pkg:
  - typedef pal_color_t (12-bit {r,g,b}).
  - Constants PAL_ENTRIES=64, PAL_IDX_W=6.
  - State enum fade_state_t.
- Sub-module color_step: combinational, inputs old and tgt (pal_color_t), outputs new and changed. Instantiated once.
- The top level holds the FSM, counters and port mux.

## Test plan
- Fade from black: preload all entries with 0x000, target 0xFFF, rate 0, tick every 100 cycles. Required: entry values 0x111, 0x222, … after each tick; fade_done after the 16th tick's sweep; every entry reads 0xFFF.
- Rate divider: rate=2, one entry 0x800, target 0x000. Required: the entry decrements only on ticks 3, 6, 9, …; fade_busy stays high throughout.
- CPU contention: bus_sel high on every other cycle during a sweep. Required: the sweep takes 128 cycles; CPU write of 0x0A5 to entry 40 lands intact; the result equals a per-component single step from each old value.
- Mixed directions: entry 0x4C7, target 0x7A7. Required sequence: 0x5B7, 0x6A7, 0x7A7, then done on the next sweep.
- Restart and abort: fade_start mid-sweep with a new target. Required: idx restarts at 0 on the next SWEEP. fade_abort asserted with fade_start in the same cycle gives IDLE with no fade_done and no further pal_wren from the engine.
- Reset mid-sweep: assert reset_n low during SWEEP. Required: pal_wren drops immediately, fade_busy=0, and IDLE after release.
